// File: rtl/feature_pkg.sv
// Shared types and helpers for the lagged-difference feature detector.
package feature_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic MODE_SIGNED = 1'b0;
  localparam logic MODE_ABS    = 1'b1;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/feature_lag_line.sv
// One channel's sample delay line plus a warm-up counter that
// saturates once the line holds LAG real samples.
module feature_lag_line
  import feature_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LAG    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_tail,
  output logic              o_warm
);

  localparam int CW = $clog2(LAG + 1);

  logic [DATA_W-1:0] r_hist [LAG];
  logic [CW-1:0]     r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAG; i++) r_hist[i] <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      for (int i = 0; i < LAG; i++) r_hist[i] <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_hist[0] <= i_data;
      for (int i = 1; i < LAG; i++) r_hist[i] <= r_hist[i-1];
      if (r_cnt != CW'(LAG)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tail = r_hist[LAG-1];
  assign o_warm = (r_cnt == CW'(LAG));

endmodule

// File: rtl/feature_absdiff_detector.sv
// Multichannel lagged-difference threshold detector: stage 1 forms
// d = x[n]-x[n-LAG], stage 2 thresholds it and applies refractory gating.
module feature_absdiff_detector
  import feature_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int NUM_CH  = 4,
  parameter int LAG     = 2,
  parameter int REFRACT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      mode,
  input  logic [DATA_W:0]           thresh,
  input  logic                      in_valid,
  input  logic [ch_w(NUM_CH)-1:0]   in_ch,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      out_valid,
  output logic [ch_w(NUM_CH)-1:0]   out_ch,
  output logic [DATA_W:0]           out_mag,
  output logic                      out_event
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int RW   = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  logic              w_ch_ok;
  logic              w_accept;
  logic [NUM_CH-1:0] w_shift;
  logic [NUM_CH-1:0] w_warm_v;
  logic [DATA_W-1:0] w_tail [NUM_CH];
  logic [DATA_W-1:0] w_tail_sel;
  logic              w_warm_sel;
  logic [DATA_W:0]   w_d;

  if (2 ** CH_W == NUM_CH) begin : g_pow2
    assign w_ch_ok = 1'b1;
  end else begin : g_npow2
    assign w_ch_ok = (in_ch < CH_W'(NUM_CH));
  end

  assign w_accept = in_valid & ~clear & w_ch_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_shift[g] = w_accept & (in_ch == CH_W'(g));
    feature_lag_line #(
      .DATA_W (DATA_W),
      .LAG    (LAG)
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .i_shift(w_shift[g]),
      .i_data (in_data),
      .o_tail (w_tail[g]),
      .o_warm (w_warm_v[g])
    );
  end

  always_comb begin
    w_tail_sel = '0;
    w_warm_sel = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == CH_W'(c)) begin
        w_tail_sel = w_tail[c];
        w_warm_sel = w_warm_v[c];
      end
    end
  end

  // one extra bit makes the difference of two DATA_W values exact
  assign w_d = {in_data[DATA_W-1], in_data}
             - {w_tail_sel[DATA_W-1], w_tail_sel};

  logic            r_s1_valid;
  logic [CH_W-1:0] r_s1_ch;
  logic [DATA_W:0] r_s1_d;
  logic            r_s1_warm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_d     <= '0;
      r_s1_warm  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_ch   <= in_ch;
        r_s1_d    <= w_d;
        r_s1_warm <= w_warm_sel;
      end
    end
  end

  logic [RW-1:0]   r_refr [NUM_CH];
  logic [RW-1:0]   w_refr_sel;
  logic [DATA_W:0] w_abs;
  logic [DATA_W:0] w_mag;
  logic            w_hit;
  logic            w_event;

  assign w_abs = r_s1_d[DATA_W] ? (~r_s1_d + 1'b1) : r_s1_d;
  assign w_mag = (mode == MODE_ABS) ? w_abs : r_s1_d;
  assign w_hit = (mode == MODE_ABS)
               ? (w_abs > thresh)
               : ($signed({r_s1_d[DATA_W], r_s1_d})
                  > $signed({1'b0, thresh}));

  always_comb begin
    w_refr_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_s1_ch == CH_W'(c)) w_refr_sel = r_refr[c];
    end
  end

  assign w_event = r_s1_valid & w_hit & r_s1_warm
                 & (w_refr_sel == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) r_refr[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) r_refr[c] <= '0;
    end else if (r_s1_valid) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_s1_ch == CH_W'(c)) begin
          if (w_event)
            r_refr[c] <= RW'(REFRACT);
          else if (r_refr[c] != '0)
            r_refr[c] <= r_refr[c] - 1'b1;
        end
      end
    end
  end

  logic            r_out_valid;
  logic [CH_W-1:0] r_out_ch;
  logic [DATA_W:0] r_out_mag;
  logic            r_out_event;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_mag   <= '0;
      r_out_event <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid & ~clear;
      r_out_event <= w_event & ~clear;
      if (r_s1_valid & ~clear) begin
        r_out_ch  <= r_s1_ch;
        r_out_mag <= w_mag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_mag   = r_out_mag;
  assign out_event = r_out_event;

endmodule

// File: tb/tb_feature_absdiff_detector.sv
// Bench for feature_absdiff_detector: two configurations share one
// input stream and are checked against a per-channel sample-list model.
module tb_feature_absdiff_detector;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          mode = 1'b0;
  logic [DW:0]   thresh = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_ch = '0;
  logic [DW-1:0] in_data = '0;

  logic          o1_valid, o1_event, o2_valid, o2_event;
  logic [1:0]    o1_ch, o2_ch;
  logic [DW:0]   o1_mag, o2_mag;

  always #5 clk = ~clk;

  feature_absdiff_detector u_dut (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .thresh(thresh), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .out_valid(o1_valid), .out_ch(o1_ch),
    .out_mag(o1_mag), .out_event(o1_event)
  );

  feature_absdiff_detector #(
    .DATA_W(16), .NUM_CH(3), .LAG(1), .REFRACT(0)
  ) u_lag1 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .thresh(thresh), .in_valid(in_valid), .in_ch(in_ch),
    .in_data(in_data), .out_valid(o2_valid), .out_ch(o2_ch),
    .out_mag(o2_mag), .out_event(o2_event)
  );

  int total = 0;
  int bad = 0;

  int lagv [2] = '{2, 1};
  int nchv [2] = '{4, 3};
  int refv [2] = '{4, 0};

  int hq   [2][4][$];
  int cnt  [2][4];
  int last [2][4];

  typedef struct {
    bit v; int ch; int d; bit warm;
  } s1_t;
  typedef struct {
    bit v; int ch; int mag; bit ev;
  } eo_t;

  s1_t s1m [2];
  eo_t eo  [2];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 4; c++) begin
        hq[i][c].delete();
        cnt[i][c] = 0;
        last[i][c] = -1000;
      end
      s1m[i].v = 1'b0;
      eo[i].v = 1'b0;
      eo[i].ev = 1'b0;
    end
  endtask

  task automatic cmp_inst(input string tag, input int i,
                          input logic v, input logic ev,
                          input logic [1:0] ch, input logic [16:0] mag);
    logic [16:0] em;
    chk($sformatf("%s_valid", tag), 32'(v), 32'(eo[i].v));
    chk($sformatf("%s_event", tag), 32'(ev), 32'(eo[i].ev));
    if (eo[i].v) begin
      em = 17'(eo[i].mag);
      chk($sformatf("%s_ch", tag), 32'(ch), 32'(eo[i].ch));
      chk($sformatf("%s_mag", tag), 32'(mag), 32'(em));
    end
  endtask

  // one clock: drive a sample, advance the model's two stages, compare
  task automatic step(input bit v, input int ch, input int data,
                      input bit clr);
    int n, old, c, a;
    bit hit;
    in_valid = v;
    in_ch = 2'(ch);
    in_data = 16'(data);
    clear = clr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      eo[i].v = s1m[i].v;
      eo[i].ev = 1'b0;
      if (s1m[i].v) begin
        c = s1m[i].ch;
        a = iabs(s1m[i].d);
        eo[i].ch = c;
        eo[i].mag = mode ? a : s1m[i].d;
        hit = mode ? (a > int'(thresh)) : (s1m[i].d > int'(thresh));
        eo[i].ev = hit && s1m[i].warm
                && (cnt[i][c] - last[i][c] > refv[i]);
        if (eo[i].ev) last[i][c] = cnt[i][c];
        cnt[i][c]++;
      end
      s1m[i].v = v && !clr && (ch < nchv[i]);
      if (s1m[i].v) begin
        n = hq[i][ch].size();
        old = (n >= lagv[i]) ? hq[i][ch][n - lagv[i]] : 0;
        s1m[i].ch = ch;
        s1m[i].d = data - old;
        s1m[i].warm = (n >= lagv[i]);
        hq[i][ch].push_back(data);
      end
    end
    if (clr) model_reset();
    cmp_inst("lag2", 0, o1_valid, o1_event, o1_ch, o1_mag);
    cmp_inst("lag1", 1, o2_valid, o2_event, o2_ch, o2_mag);
  endtask

  task automatic chk_zero(input string tag);
    chk($sformatf("%s_v1", tag), 32'(o1_valid), 32'd0);
    chk($sformatf("%s_e1", tag), 32'(o1_event), 32'd0);
    chk($sformatf("%s_c1", tag), 32'(o1_ch), 32'd0);
    chk($sformatf("%s_m1", tag), 32'(o1_mag), 32'd0);
    chk($sformatf("%s_v2", tag), 32'(o2_valid), 32'd0);
    chk($sformatf("%s_e2", tag), 32'(o2_event), 32'd0);
    chk($sformatf("%s_c2", tag), 32'(o2_ch), 32'd0);
    chk($sformatf("%s_m2", tag), 32'(o2_mag), 32'd0);
  endtask

  initial begin
    int evmask;
    int dat;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // warm-up, first crossing, refractory on the next sample
    mode = 1'b0;
    thresh = 17'd500;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 600, 0);
    step(1, 0, 600, 0);
    chk("t1_ev4", 32'(o1_event), 32'd1);
    chk("t1_mag4", 32'(o1_mag), 32'd600);
    step(0, 0, 0, 0);
    chk("t1_v5", 32'(o1_valid), 32'd1);
    chk("t1_ev5", 32'(o1_event), 32'd0);

    // falling step: absolute mode fires, signed mode does not
    step(0, 0, 0, 1);
    mode = 1'b1;
    step(1, 1, 1000, 0);
    step(1, 1, 1000, 0);
    step(1, 1, 300, 0);
    step(0, 0, 0, 0);
    chk("t2_abs_mag", 32'(o1_mag), 32'd700);
    chk("t2_abs_ev", 32'(o1_event), 32'd1);
    chk("t2_abs_ch", 32'(o1_ch), 32'd1);
    step(0, 0, 0, 1);
    mode = 1'b0;
    step(1, 1, 1000, 0);
    step(1, 1, 1000, 0);
    step(1, 1, 300, 0);
    step(0, 0, 0, 0);
    chk("t2_sgn_ev", 32'(o1_event), 32'd0);
    chk("t2_sgn_mag", 32'(o1_mag), 32'h1FD44);

    // round-robin, only ch2 steps
    step(0, 0, 0, 1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        step(1, c, (c == 2) ? ((r == 2) ? 1000 : 0) : 777, 0);
        if (r == 2 && c == 3) begin
          chk("t3_ev", 32'(o1_event), 32'd1);
          chk("t3_ch", 32'(o1_ch), 32'd2);
        end
      end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // refractory with ch1 traffic interleaved
    step(0, 0, 0, 1);
    thresh = 17'd100;
    evmask = 0;
    for (int k = 1; k <= 13; k++) begin
      step(1, 0, k * 1000, 0);
      step(1, 1, 5, 0);
      if (o1_event === 1'b1) evmask |= (1 << k);
    end
    chk("t4_events", 32'(evmask), 32'((1 << 3) | (1 << 8) | (1 << 13)));
    step(0, 0, 0, 0);

    // full-scale extremes on the LAG=1 instance
    step(0, 0, 0, 1);
    mode = 1'b1;
    thresh = 17'd65534;
    step(1, 0, -32768, 0);
    step(1, 0, 32767, 0);
    step(0, 0, 0, 0);
    chk("t5_abs_mag", 32'(o2_mag), 32'd65535);
    chk("t5_abs_ev", 32'(o2_event), 32'd1);
    step(0, 0, 0, 1);
    mode = 1'b0;
    thresh = 17'd65535;
    step(1, 0, -32768, 0);
    step(1, 0, 32767, 0);
    step(0, 0, 0, 0);
    chk("t5_sgn_ev", 32'(o2_event), 32'd0);
    chk("t5_sgn_mag", 32'(o2_mag), 32'd65535);
    step(1, 3, 100, 0);
    step(0, 0, 0, 0);
    chk("t5_drop_v2", 32'(o2_valid), 32'd0);
    chk("t5_keep_v1", 32'(o1_valid), 32'd1);

    // clear with samples in flight restarts warm-up
    step(0, 0, 0, 1);
    mode = 1'b1;
    thresh = 17'd0;
    step(1, 0, 50, 0);
    step(1, 0, 60, 0);
    step(1, 0, 70, 1);
    chk("t6_flush_a", 32'(o1_valid), 32'd0);
    step(0, 0, 0, 0);
    chk("t6_flush_b", 32'(o1_valid), 32'd0);
    step(1, 0, 80, 0);
    step(1, 0, 90, 0);
    step(0, 0, 0, 0);
    chk("t6_warm_v", 32'(o1_valid), 32'd1);
    chk("t6_warm_ev", 32'(o1_event), 32'd0);
    step(1, 0, 100, 0);
    step(0, 0, 0, 0);
    chk("t6_post_ev", 32'(o1_event), 32'd1);

    // asynchronous reset in the middle of a cycle
    step(1, 2, 1234, 0);
    step(0, 0, 0, 0);
    chk("t6_pre_rst_v", 32'(o1_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1, 2, 10, 0);

    // randomized traffic
    for (int t = 0; t < 1500; t++) begin
      if (t % 50 == 0) mode = 1'($urandom_range(0, 1));
      if (t % 20 == 0)
        thresh = ($urandom_range(0, 4) == 0)
               ? 17'($urandom_range(0, 70000))
               : 17'($urandom_range(0, 3000));
      if ($urandom_range(0, 1) == 0)
        dat = int'($urandom_range(0, 65535)) - 32768;
      else
        dat = int'($urandom_range(0, 4000)) - 2000;
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
           dat, $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
